// File: rtl/grid_writer_pkg.sv
// Shared grid definitions for the GridData write side (grid_writer) and the VGA read side.
// Holds grid geometry, address widths, the command op encodings and the writer FSM states.
package grid_writer_pkg;

  localparam int unsigned GridW  = 64;
  localparam int unsigned GridH  = 64;
  localparam int unsigned CoordW = 6;
  localparam int unsigned AddrW  = 12;
  localparam int unsigned ColorW = 4;

  typedef enum logic [1:0] {
    OpCell  = 2'b00,
    OpRect  = 2'b01,
    OpClear = 2'b10,
    OpNop   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCell,
    StRect,
    StClear
  } state_e;

  // Linear GridData address: row-major, x in the low bits.
  function automatic logic [AddrW-1:0] grid_addr(input logic [CoordW-1:0] y,
                                                 input logic [CoordW-1:0] x);
    return {y, x};
  endfunction

  function automatic logic [CoordW-1:0] coord_min(input logic [CoordW-1:0] a,
                                                  input logic [CoordW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CoordW-1:0] coord_max(input logic [CoordW-1:0] a,
                                                  input logic [CoordW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// Raster x/y counter over an inclusive rectangle [x_min..x_max] x [y_min..y_max].
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (counters go to 0)
//   load_i             capture bounds and park at (x_min_i, y_min_i)
//   step_i             advance to the next position, x fastest
//   x_*_i, y_*_i       rectangle bounds, valid while load_i is high
//   x_nxt_o, y_nxt_o   position the next step moves to
//   last_o             current position is the final cell of the rectangle
module grid_scan_counter
  import grid_writer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [CoordW-1:0] x_min_i,
  input  logic [CoordW-1:0] x_max_i,
  input  logic [CoordW-1:0] y_min_i,
  input  logic [CoordW-1:0] y_max_i,
  output logic [CoordW-1:0] x_nxt_o,
  output logic [CoordW-1:0] y_nxt_o,
  output logic              last_o
);

  logic [CoordW-1:0] x_q, x_d, y_q, y_d;
  logic [CoordW-1:0] x_min_q, x_min_d, x_max_q, x_max_d, y_max_q, y_max_d;
  logic              row_end;

  // Row/grid ends come from bound compares, so a 0..63 scan never relies on 6-bit overflow.
  always_comb begin
    row_end = (x_q == x_max_q);
    x_nxt_o = row_end ? x_min_q : x_q + 6'd1;
    y_nxt_o = row_end ? y_q + 6'd1 : y_q;
    last_o  = row_end && (y_q == y_max_q);

    x_d     = x_q;
    y_d     = y_q;
    x_min_d = x_min_q;
    x_max_d = x_max_q;
    y_max_d = y_max_q;
    if (load_i) begin
      x_d     = x_min_i;
      y_d     = y_min_i;
      x_min_d = x_min_i;
      x_max_d = x_max_i;
      y_max_d = y_max_i;
    end else if (step_i && !last_o) begin
      x_d = x_nxt_o;
      y_d = y_nxt_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q     <= '0;
      y_q     <= '0;
      x_min_q <= '0;
      x_max_q <= '0;
      y_max_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      x_min_q <= x_min_d;
      x_max_q <= x_max_d;
      y_max_q <= y_max_d;
    end
  end

endmodule

// File: rtl/grid_writer.sv
// GridData writer: executes cell / rect-fill / clear-all commands as one write per cycle.
// Ports:
//   iVGA_CLK, iRST_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake; cmd_op, cmd_x0/y0/x1/y1, cmd_color
//   wren_gridData, data_gridData, wraddress_gridData   registered GridData write port
//   busy                      operation in progress (inverse of cmd_ready)
//   done                      one-cycle pulse the cycle after the final write
module grid_writer
  import grid_writer_pkg::*;
#(
  parameter int unsigned       GRID_W         = GridW,
  parameter int unsigned       GRID_H         = GridH,
  parameter logic [ColorW-1:0] CLEAR_COLOR    = 4'd0,
  parameter int unsigned       CLEAR_ON_RESET = 1
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CoordW-1:0] cmd_x0,
  input  logic [CoordW-1:0] cmd_y0,
  input  logic [CoordW-1:0] cmd_x1,
  input  logic [CoordW-1:0] cmd_y1,
  input  logic [ColorW-1:0] cmd_color,
  output logic              wren_gridData,
  output logic [ColorW-1:0] data_gridData,
  output logic [AddrW-1:0]  wraddress_gridData,
  output logic              busy,
  output logic              done
);

  localparam logic [CoordW-1:0] XLast = CoordW'(GRID_W - 1);
  localparam logic [CoordW-1:0] YLast = CoordW'(GRID_H - 1);

  state_e            state_q, state_d;
  logic              wren_q, wren_d, done_q, done_d;
  logic [ColorW-1:0] data_q, data_d, color_q, color_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  // Requests the power-up clear; set by reset so an aborted clear restarts from 0.
  logic              clr_pend_q, clr_pend_d;

  logic              cnt_load, cnt_step, cnt_last;
  logic [CoordW-1:0] ld_x_min, ld_x_max, ld_y_min, ld_y_max, x_nxt, y_nxt;

  // Held low while the power-up clear is pending so no command can slip in unseen.
  assign cmd_ready          = (state_q == StIdle) && !clr_pend_q;
  assign busy               = ~cmd_ready;
  assign wren_gridData      = wren_q;
  assign data_gridData      = data_q;
  assign wraddress_gridData = addr_q;
  assign done               = done_q;

  grid_scan_counter u_scan (
    .clk_i   (iVGA_CLK),
    .rst_ni  (iRST_n),
    .load_i  (cnt_load),
    .step_i  (cnt_step),
    .x_min_i (ld_x_min),
    .x_max_i (ld_x_max),
    .y_min_i (ld_y_min),
    .y_max_i (ld_y_max),
    .x_nxt_o (x_nxt),
    .y_nxt_o (y_nxt),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    wren_d     = 1'b0;
    done_d     = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;
    color_d    = color_q;
    clr_pend_d = clr_pend_q;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    ld_x_min   = coord_min(cmd_x0, cmd_x1);
    ld_x_max   = coord_max(cmd_x0, cmd_x1);
    ld_y_min   = coord_min(cmd_y0, cmd_y1);
    ld_y_max   = coord_max(cmd_y0, cmd_y1);

    unique case (state_q)
      StIdle: begin
        if (clr_pend_q || (cmd_valid && op_e'(cmd_op) == OpClear)) begin
          clr_pend_d = 1'b0;
          state_d    = StClear;
          ld_x_min   = '0;
          ld_x_max   = XLast;
          ld_y_min   = '0;
          ld_y_max   = YLast;
          cnt_load   = 1'b1;
          wren_d     = 1'b1;
          data_d     = CLEAR_COLOR;
          addr_d     = '0;
        end else if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OpCell: begin
              state_d = StCell;
              wren_d  = 1'b1;
              data_d  = cmd_color;
              addr_d  = grid_addr(cmd_y0, cmd_x0);
            end
            OpRect: begin
              // First write goes out with acceptance; the counter then walks the rest.
              state_d  = StRect;
              cnt_load = 1'b1;
              wren_d   = 1'b1;
              data_d   = cmd_color;
              color_d  = cmd_color;
              addr_d   = grid_addr(ld_y_min, ld_x_min);
            end
            OpNop:   done_d = 1'b1;
            default: ;
          endcase
        end
      end
      StCell: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StRect, StClear: begin
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_step = 1'b1;
          wren_d   = 1'b1;
          data_d   = (state_q == StRect) ? color_q : CLEAR_COLOR;
          addr_d   = grid_addr(y_nxt, x_nxt);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= StIdle;
      wren_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      color_q    <= '0;
      clr_pend_q <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q    <= state_d;
      wren_q     <= wren_d;
      done_q     <= done_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      color_q    <= color_d;
      clr_pend_q <= clr_pend_d;
    end
  end

endmodule

// File: doc/grid_writer.md
GRID_WRITER -- requirements
Module: grid_writer

Interface
REQ-001 SHALL have parameter GRID_W, 64, grid columns; addresses are 6-bit.
REQ-002 SHALL have parameter GRID_H, 64, grid rows; addresses are 6-bit.
REQ-003 SHALL have parameter CLEAR_COLOR, 4'd0, colour index written by clear operations.
REQ-004 SHALL have parameter CLEAR_ON_RESET, 1, a nonzero value auto-runs a full clear after reset release.
REQ-005 SHALL have port iVGA_CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port iRST_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid  in  1  command present.
REQ-008 SHALL have port cmd_ready  out  1  block can accept a command.
REQ-009 SHALL have port cmd_op  in  2  00 cell, 01 rect fill, 10 clear all, 11 no-op.
REQ-010 SHALL have ports cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  6 each  corner coordinates; cell op uses x0/y0 only.
REQ-011 SHALL have port cmd_color  in  4  colour index for cell/rect.
REQ-012 SHALL have port wren_gridData  out  1  GridData write enable.
REQ-013 SHALL have port data_gridData  out  4  GridData write data.
REQ-014 SHALL have port wraddress_gridData  out  12  GridData write address = y*64+x = {y,x}.
REQ-015 SHALL have port busy  out  1  operation in progress.
REQ-016 SHALL have port done  out  1  one-cycle pulse on operation completion.

Function
REQ-017 SHALL implement FSM states IDLE, CELL, RECT, CLEAR.
REQ-018 SHALL drive cmd_ready = (state==IDLE) and busy = ~cmd_ready.
REQ-019 SHALL accept a command on a rising edge with cmd_valid&&cmd_ready, capturing all cmd_* fields.
REQ-020 SHALL register all write-port outputs, with the first write appearing in the cycle after acceptance.
REQ-021 SHALL have CELL issue exactly one write to {y0,x0} with cmd_color, then return to IDLE.
REQ-022 SHALL have RECT normalise corners (xmin=min(x0,x1), etc.) and write every cell, row-major (x fastest), one write per cycle, no gaps; total writes=(xmax-xmin+1)*(ymax-ymin+1).
REQ-023 SHALL have CLEAR write CLEAR_COLOR to addresses 0..4095 ascending, one per cycle, 4096 writes.
REQ-024 SHALL treat op 11 as accepted, zero writes, with done pulsing the next cycle.
REQ-025 SHALL pulse done for exactly one cycle, in the cycle after the final write; cmd_ready rises in that same cycle.
REQ-026 SHALL hold wren_gridData low whenever no write is issued, and SHALL hold data/address at their last values.
REQ-027 SHALL ignore cmd_valid while busy; the command is neither captured nor lost, and the source holds it.
REQ-028 SHALL have back-to-back commands accepted in the done cycle start writing the following cycle, giving one idle write cycle between operations.
REQ-029 SHALL keep x/y counters 6 bits wide; end-of-row and end-of-grid are detected by comparison, not overflow, and counters never wrap mid-rect.

Reset
REQ-030 SHALL, on iRST_n low, immediately (asynchronously) set state IDLE, wren_gridData=0, data_gridData=0, wraddress_gridData=0, done=0, and all counters to 0.
REQ-031 SHALL, on reset asserted mid-operation, abort the operation with no further writes and no done pulse.
REQ-032 SHALL, after release with CLEAR_ON_RESET!=0, enter CLEAR on the first clock (cmd_ready low, 4096 writes, then done); with CLEAR_ON_RESET==0, enter IDLE.

Structure
REQ-033 SHALL place op encodings, GRID_W/GRID_H and address-width constants in a shared grid package used also by the VGA read side.
REQ-034 SHALL contain one sub-module, grid_scan_counter (6-bit x/y raster counter with bounds, load and last flag), shared by RECT and CLEAR.

Verification
REQ-035 SHALL check, with CLEAR_ON_RESET=1 and reset released: 4096 writes, addr 0..4095, data 0; done at cycle 4097; cmd_ready high afterwards.
REQ-036 SHALL check that cell x0=5,y0=3,color=7 produces one write, addr 197, data 7, done next cycle.
REQ-037 SHALL check that rect x0=10,y0=2,x1=8,y1=1,color=A produces 6 writes, addrs 72,73,74,136,137,138, in order.
REQ-038 SHALL check that a second command held valid during a rect is accepted only in the done cycle, with its first write one cycle later.
REQ-039 SHALL check that iRST_n pulsed low during write 100 of a clear drops wren immediately, outputs are 0, no done, then the clear restarts from addr 0.
REQ-040 SHALL check that rect 0,0 to 63,63 produces 4096 writes, last addr 4095, and the counters do not wrap.
